// File: rtl/valtrain_pkg.sv
// Shared types and defaults for the MBINIT valid-training detector controller.
package valtrain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } vt_state_e;

    typedef enum logic [1:0] {
        DET_IDLE      = 2'b00,
        DET_ITER_128  = 2'b01,
        DET_CONSEC_16 = 2'b10
    } det_mode_e;

    localparam int DEF_ITER_BEATS     = 32;
    localparam int DEF_SETTLE_CYC     = 2;
    localparam int DEF_MIN_CONS_BEATS = 4;
    localparam int DEF_TIMEOUT_CYC    = 1024;
    localparam int BEAT_CNT_W         = 8;

    function automatic det_mode_e mode_sel(input logic cons);
        return cons ? DET_CONSEC_16 : DET_ITER_128;
    endfunction

endpackage

// File: rtl/valtrain_detect_ctrl_if.sv
// LTSM/detector-facing signal bundle of valtrain_detect_ctrl; slave = controller side.
interface valtrain_detect_ctrl_if;
    logic        i_start;
    logic        i_mode;
    logic [11:0] i_error_threshold;
    logic        i_abort;
    logic        i_beat_valid;
    logic        i_detection_result;
    logic        o_enable_detector;
    logic        o_enable_128;
    logic        o_enable_cons;
    logic [11:0] o_error_threshold;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic        o_timeout;

    modport slave (
        input  i_start, i_mode, i_error_threshold, i_abort, i_beat_valid, i_detection_result,
        output o_enable_detector, o_enable_128, o_enable_cons, o_error_threshold,
               o_busy, o_done, o_pass, o_timeout
    );

    modport master (
        output i_start, i_mode, i_error_threshold, i_abort, i_beat_valid, i_detection_result,
        input  o_enable_detector, o_enable_128, o_enable_cons, o_error_threshold,
               o_busy, o_done, o_pass, o_timeout
    );
endinterface

// File: rtl/valtrain_run_counter.sv
// Beat and RUN-cycle counters for one training attempt; both saturate, never wrap.
module valtrain_run_counter
    import valtrain_pkg::*;
#(
    parameter int ITER_BEATS     = DEF_ITER_BEATS,
    parameter int MIN_CONS_BEATS = DEF_MIN_CONS_BEATS,
    parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_beat_inc,
    input  logic i_cyc_inc,
    output logic o_beat_last,
    output logic o_beat_min_ok,
    output logic o_cyc_last
);
    localparam int CYC_W = $clog2(TIMEOUT_CYC) + 1;

    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CYC_W-1:0]      cyc_cnt_q, cyc_cnt_d;

    // Next-count logic: clear wins, otherwise saturating increments.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        if (i_clr) begin
            beat_cnt_d = '0;
            cyc_cnt_d  = '0;
        end else begin
            if (i_beat_inc && (beat_cnt_q != {BEAT_CNT_W{1'b1}})) begin
                beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
            end else begin
                beat_cnt_d = beat_cnt_q;
            end
            if (i_cyc_inc && (cyc_cnt_q != {CYC_W{1'b1}})) begin
                cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
            end else begin
                cyc_cnt_d = cyc_cnt_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt_q <= '0;
            cyc_cnt_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    assign o_beat_last   = (beat_cnt_q == BEAT_CNT_W'(ITER_BEATS - 1));
    assign o_beat_min_ok = (beat_cnt_q >= BEAT_CNT_W'(MIN_CONS_BEATS));
    assign o_cyc_last    = (cyc_cnt_q == CYC_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/valtrain_detect_ctrl.sv
// Sequences the valid-lane pattern detector through one MBINIT valid-training run.
// Optional VALTRAIN_AUTO_RETRY_EN: a failed run is retried once before reporting.
module valtrain_detect_ctrl
    import valtrain_pkg::*;
#(
    parameter int ITER_BEATS     = DEF_ITER_BEATS,
    parameter int SETTLE_CYC     = DEF_SETTLE_CYC,
    parameter int MIN_CONS_BEATS = DEF_MIN_CONS_BEATS,
    parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    valtrain_detect_ctrl_if.slave  bus
);
    localparam int SETTLE_W = $clog2(SETTLE_CYC) + 1;

    vt_state_e             state_q, state_d;
    logic                  mode_q, mode_d;
    logic [11:0]           thr_q, thr_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  fail_s, fail_to_s;
    logic                  beat_last_s, beat_min_ok_s, cyc_last_s;
    logic                  en_det_s;
    det_mode_e             mode_bits_s;
`ifdef VALTRAIN_AUTO_RETRY_EN
    logic                  retry_q, retry_d;
`endif

    valtrain_run_counter #(
        .ITER_BEATS     (ITER_BEATS),
        .MIN_CONS_BEATS (MIN_CONS_BEATS),
        .TIMEOUT_CYC    (TIMEOUT_CYC)
    ) u_cnt (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clr         (state_q == ST_CLEAR),
        .i_beat_inc    ((state_q == ST_RUN) && bus.i_beat_valid),
        .i_cyc_inc     (state_q == ST_RUN),
        .o_beat_last   (beat_last_s),
        .o_beat_min_ok (beat_min_ok_s),
        .o_cyc_last    (cyc_last_s)
    );

    // Next-state and result logic; abort overrides everything at the end.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        thr_d     = thr_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        settle_d  = settle_q;
        fail_s    = 1'b0;
        fail_to_s = 1'b0;
`ifdef VALTRAIN_AUTO_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    mode_d    = bus.i_mode;
                    thr_d     = bus.i_error_threshold;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
`ifdef VALTRAIN_AUTO_RETRY_EN
                    retry_d   = 1'b0;
`endif
                    state_d   = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                if (!mode_q) begin
                    if (bus.i_beat_valid && beat_last_s) begin
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (bus.i_detection_result && beat_min_ok_s) begin
                    pass_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cyc_last_s) begin
                    pass_d    = 1'b0;
                    fail_s    = 1'b1;
                    fail_to_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) begin
                    pass_d = bus.i_detection_result;
                    if (bus.i_detection_result) begin
                        state_d = ST_DONE;
                    end else begin
                        fail_s = 1'b1;
                    end
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (fail_s) begin
`ifdef VALTRAIN_AUTO_RETRY_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                pass_d    = 1'b0;
                timeout_d = 1'b0;
                state_d   = ST_CLEAR;
            end else begin
                timeout_d = fail_to_s;
                state_d   = ST_DONE;
            end
`else
            timeout_d = fail_to_s;
            state_d   = ST_DONE;
`endif
        end else begin
            timeout_d = timeout_d;
        end

        if (bus.i_abort && (state_q != ST_IDLE)) begin
            pass_d  = 1'b0;
            state_d = ST_IDLE;
        end else begin
            pass_d = pass_d;
        end
    end

    // Control and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            thr_q     <= 12'h000;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            settle_q  <= '0;
`ifdef VALTRAIN_AUTO_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            thr_q     <= thr_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            settle_q  <= settle_d;
`ifdef VALTRAIN_AUTO_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    // Detector enables: the enable follows real beats only while running.
    always_comb begin
        en_det_s    = 1'b0;
        mode_bits_s = DET_IDLE;
        case (state_q)
            ST_CLEAR:  en_det_s = 1'b1;
            ST_RUN: begin
                en_det_s    = bus.i_beat_valid;
                mode_bits_s = mode_sel(mode_q);
            end
            ST_SETTLE: mode_bits_s = mode_sel(mode_q);
            default: begin
                en_det_s    = 1'b0;
                mode_bits_s = DET_IDLE;
            end
        endcase
    end

    assign bus.o_enable_detector = en_det_s;
    assign bus.o_enable_128      = mode_bits_s[0];
    assign bus.o_enable_cons     = mode_bits_s[1];
    assign bus.o_error_threshold = thr_q;
    assign bus.o_busy            = (state_q != ST_IDLE);
    assign bus.o_done            = (state_q == ST_DONE);
    assign bus.o_pass            = pass_q;
    assign bus.o_timeout         = timeout_q;

endmodule

// File: tb/tb_valtrain_detect_ctrl.sv
// Directed self-checking bench for valtrain_detect_ctrl (default build).
module tb_valtrain_detect_ctrl;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   en_cnt;
    int   gap_cnt;
    int   dn_cnt;
    int   n;
    logic found;

    valtrain_detect_ctrl_if bus ();

    valtrain_detect_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    // {en_det, en_128, en_cons, busy, done, pass, timeout}
    logic [6:0] outs;
    assign outs = {bus.o_enable_detector, bus.o_enable_128, bus.o_enable_cons,
                   bus.o_busy, bus.o_done, bus.o_pass, bus.o_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start at a negedge; returns at the negedge where the DUT sits in CLEAR.
    task automatic do_start(input logic mode, input logic [11:0] thr);
        bus.i_start           = 1'b1;
        bus.i_mode            = mode;
        bus.i_error_threshold = thr;
        @(negedge clk);
        bus.i_start = 1'b0;
        #1;
    endtask

    task automatic do_beats(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            bus.i_beat_valid = 1'b1;
            #1;
            if (bus.o_enable_detector) en_cnt++;
            @(negedge clk);
        end
        bus.i_beat_valid = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_mode = 1'b0; bus.i_error_threshold = 12'h000;
        bus.i_abort = 1'b0; bus.i_beat_valid = 1'b0; bus.i_detection_result = 1'b0;

        @(negedge clk);
        chk("reset_outs", 32'(outs), 32'd0);
        chk("reset_thr", 32'(bus.o_error_threshold), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", 32'(outs), 32'd0);

        // ITER_128, 32 back-to-back beats, pass sampled in last SETTLE cycle
        do_start(1'b0, 12'd10);
        chk("t1_clear", 32'(outs), 32'b1001000);
        chk("t1_thr", 32'(bus.o_error_threshold), 32'd10);
        @(negedge clk);
        en_cnt = 0;
        do_beats(32);
        #1;
        chk("t1_en_cnt", en_cnt, 32'd32);
        chk("t1_settle0", 32'(outs), 32'b0101000);
        @(negedge clk);
        bus.i_detection_result = 1'b1;
        #1;
        chk("t1_settle1", 32'(outs), 32'b0101000);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_mode = 1'b1;
        #1;
        chk("t1_done", 32'(outs), 32'b0001110);
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_detection_result = 1'b0;
        #1;
        chk("t1_idle_pass_held", 32'(outs), 32'b0000010);
        @(negedge clk);
        chk("t1_start_in_done_ignored", 32'(outs), 32'b0000010);

        // ITER_128 with beats every other cycle, result 0
        do_start(1'b0, 12'd5);
        chk("t2_clear_clears_pass", 32'(outs), 32'b1001000);
        @(negedge clk);
        en_cnt = 0; gap_cnt = 0; dn_cnt = 0;
        for (int i = 0; i < 63; i++) begin
            bus.i_beat_valid = ((i % 2) == 0);
            #1;
            if (bus.o_enable_detector && bus.i_beat_valid) en_cnt++;
            if (bus.o_enable_detector && !bus.i_beat_valid) gap_cnt++;
            if (bus.o_done) dn_cnt++;
            @(negedge clk);
        end
        bus.i_beat_valid = 1'b0;
        #1;
        chk("t2_en_cnt", en_cnt, 32'd32);
        chk("t2_gap_en", gap_cnt, 32'd0);
        chk("t2_early_done", dn_cnt, 32'd0);
        chk("t2_settle0", 32'(outs), 32'b0101000);
        @(negedge clk);
        @(negedge clk);
        chk("t2_done_fail", 32'(outs), 32'b0001100);
        @(negedge clk);
        chk("t2_idle", 32'(outs), 32'd0);

        // CONSEC_16, result high from CLEAR on; guard needs 4 counted beats
        do_start(1'b1, 12'd7);
        bus.i_detection_result = 1'b1;
        #1;
        chk("t3_clear", 32'(outs), 32'b1001000);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            bus.i_beat_valid = 1'b1;
            #1;
            chk($sformatf("t3_run%0d", k), 32'(outs), 32'b1011000);
            @(negedge clk);
        end
        bus.i_beat_valid = 1'b0;
        #1;
        chk("t3_done_pass", 32'(outs), 32'b0001110);
        @(negedge clk);
        bus.i_detection_result = 1'b0;
        #1;
        chk("t3_idle", 32'(outs), 32'b0000010);

        // CONSEC_16, result stuck at 0 -> timeout; threshold input changed mid-run
        do_start(1'b1, 12'hABC);
        bus.i_error_threshold = 12'h123;
        @(negedge clk);
        n = 0; found = 1'b0;
        while ((n < 1100) && !found) begin
            bus.i_beat_valid = 1'b1;
            #1;
            if (bus.o_done) found = 1'b1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        chk("t4_done_seen", 32'(found), 32'd1);
        chk("t4_done_cycle", n, 32'd1024);
        chk("t4_thr_stable", 32'(bus.o_error_threshold), 32'hABC);
        chk("t4_done_timeout", 32'(outs), 32'b0001101);
        bus.i_beat_valid = 1'b0;
        @(negedge clk);
        chk("t4_timeout_held", 32'(outs), 32'b0000001);

        // Abort in the same cycle as the 32nd beat, then a clean rerun
        do_start(1'b0, 12'd1);
        @(negedge clk);
        do_beats(31);
        bus.i_beat_valid = 1'b1; bus.i_abort = 1'b1;
        #1;
        chk("t5_abort_cycle", 32'(outs), 32'b1101000);
        @(negedge clk);
        bus.i_beat_valid = 1'b0; bus.i_abort = 1'b0;
        #1;
        chk("t5_after_abort", 32'(outs), 32'd0);
        dn_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_done || bus.o_busy) dn_cnt++;
        end
        chk("t5_no_done", dn_cnt, 32'd0);
        do_start(1'b0, 12'd2);
        @(negedge clk);
        en_cnt = 0;
        do_beats(32);
        @(negedge clk);
        bus.i_detection_result = 1'b1;
        @(negedge clk);
        #1;
        chk("t5_rerun_done", 32'(outs), 32'b0001110);
        @(negedge clk);
        bus.i_detection_result = 1'b0;

        // Asynchronous reset in the middle of a RUN cycle
        do_start(1'b1, 12'h055);
        @(negedge clk);
        bus.i_beat_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_outs", 32'(outs), 32'd0);
        chk("t6_async_thr", 32'(bus.o_error_threshold), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_beat_valid = 1'b0;
        @(negedge clk);
        chk("t6_idle", 32'(outs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
